bnn_conv_pool_stream: RTL and testbench

Streaming binary-convolution neuron with optional 2x2 binary max-pool, the parametrised successor of the fixed 3x3x3 kernel-plus-pool cell. It accepts one input channel's KxK activation window and KxK weight window per beat and XNOR-popcounts them. It accumulates the signed ±1 sums over CH channel beats, applies a sign threshold, and OR-pools four consecutive activations into one output feature bit. It sits between the feature-map/weight fetch logic and the next layer's feature-map DFF storage.

---
 rtl/bnn_conv_pool_stream_if.sv | 34 +++
 rtl/bnn_conv_pool_stream.sv | 134 +++++++++++++
 tb/tb_bnn_conv_pool_stream.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_conv_pool_stream_if.sv
// bnn_conv_pool_stream_if
//   Stream bundle for the binary convolution/pool neuron.
//   Input beat side : in_valid, in_ready, in_act[KK], in_wgt[KK], in_last_ch
//   Output side     : out_valid, out_ready, out_bit, out_sum[ACC_W] (signed)
//   Status          : ch_err (sticky channel-count disagreement)
//   master = producer/consumer environment, slave = the neuron block.
interface bnn_conv_pool_stream_if #(
  parameter int KSIZE = 3,
  parameter int CH    = 3
);
  localparam int KK    = KSIZE * KSIZE;
  localparam int ACC_W = $clog2(CH * KK + 1) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [KK-1:0]           in_act;
  logic [KK-1:0]           in_wgt;
  logic                    in_last_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_bit;
  logic signed [ACC_W-1:0] out_sum;
  logic                    ch_err;

  modport master (
    output in_valid, in_act, in_wgt, in_last_ch, out_ready,
    input  in_ready, out_valid, out_bit, out_sum, ch_err
  );

  modport slave (
    input  in_valid, in_act, in_wgt, in_last_ch, out_ready,
    output in_ready, out_valid, out_bit, out_sum, ch_err
  );
endinterface

// File: rtl/bnn_conv_pool_stream.sv
// bnn_conv_pool_stream
//   Streaming binary-convolution neuron. Each accepted beat carries one
//   channel's KxK activation and weight windows; XNOR-popcount gives a
//   signed +/-1 sum, accumulated over CH beats, thresholded to one
//   activation bit, and (optionally) OR-pooled over four activations.
// Ports
//   clk  : clock, all state on rising edge
//   rstn : asynchronous reset, active HIGH despite the name
//   bus  : bnn_conv_pool_stream_if.slave (input beat stream, output
//          feature bit + accumulator sum, sticky ch_err)
// Parameters
//   KSIZE  : kernel edge (KK = KSIZE*KSIZE window bits)
//   CH     : channel beats per neuron (>= 1)
//   THRESH : signed threshold, activation = (sum >= THRESH)
// Build option
//   BNN_POOL_EN : when defined, one output per four activations (2x2 OR
//                 pool); otherwise every activation is emitted directly.
module bnn_conv_pool_stream #(
  parameter int KSIZE  = 3,
  parameter int CH     = 3,
  parameter int THRESH = 0
) (
  input logic                    clk,
  input logic                    rstn,
  bnn_conv_pool_stream_if.slave  bus
);
  localparam int KK    = KSIZE * KSIZE;
  localparam int ACC_W = $clog2(CH * KK + 1) + 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0]           CH_LAST = CW'(CH - 1);
  localparam logic signed [ACC_W-1:0] KK_S    = ACC_W'(KK);

  logic [CW-1:0]           ch_cnt_q, ch_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_bit_q, out_bit_d;
  logic                    ch_err_q, ch_err_d;
`ifdef BNN_POOL_EN
  logic [1:0]              pos_cnt_q, pos_cnt_d;
  logic                    pool_q, pool_d;
`endif

  logic [KK-1:0]           match;
  logic [ACC_W-1:0]        m;
  logic signed [ACC_W-1:0] s, acc_base, final_sum;
  logic                    in_ready, accept, last_ch, act, complete, emit, new_bit;

  always_comb begin
    match = ~(bus.in_act ^ bus.in_wgt);
    m = '0;
    for (int i = 0; i < KK; i++) m = m + ACC_W'(match[i]);
    s = $signed(m << 1) - KK_S;

    last_ch   = (ch_cnt_q == CH_LAST);
    // channel 0 starts a fresh sum; this also covers CH == 1
    acc_base  = (ch_cnt_q == '0) ? '0 : acc_q;
    final_sum = acc_base + s;
    act       = (int'(final_sum) >= THRESH);

    // a completion can only be accepted when the output slot is free
    // or is being drained on the same edge
    in_ready = ~out_valid_q | bus.out_ready;
    accept   = bus.in_valid & in_ready;
    complete = accept & last_ch;

    ch_cnt_d    = ch_cnt_q;
    acc_d       = acc_q;
    ch_err_d    = ch_err_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_sum_d   = out_sum_q;

    if (accept) begin
      acc_d    = final_sum;
      ch_cnt_d = last_ch ? '0 : ch_cnt_q + CW'(1);
      if (bus.in_last_ch != last_ch) ch_err_d = 1'b1;
    end

`ifdef BNN_POOL_EN
    pos_cnt_d = pos_cnt_q;
    pool_d    = pool_q;
    emit      = 1'b0;
    new_bit   = pool_q | act;
    if (complete) begin
      pool_d    = (pos_cnt_q == 2'd0) ? act : (pool_q | act);
      pos_cnt_d = pos_cnt_q + 2'd1;
      emit      = (pos_cnt_q == 2'd3);
    end
`else
    emit    = complete;
    new_bit = act;
`endif

    if (out_valid_q & bus.out_ready) out_valid_d = 1'b0;
    if (emit) begin
      out_valid_d = 1'b1;
      out_bit_d   = new_bit;
      out_sum_d   = final_sum;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      ch_cnt_q    <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      ch_err_q    <= 1'b0;
`ifdef BNN_POOL_EN
      pos_cnt_q   <= '0;
      pool_q      <= 1'b0;
`endif
    end else begin
      ch_cnt_q    <= ch_cnt_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      ch_err_q    <= ch_err_d;
`ifdef BNN_POOL_EN
      pos_cnt_q   <= pos_cnt_d;
      pool_q      <= pool_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bit   = out_bit_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.ch_err    = ch_err_q;
endmodule

// File: tb/tb_bnn_conv_pool_stream.sv
module tb_bnn_conv_pool_stream;
  localparam int KSIZE  = 3;
  localparam int CH     = 3;
  localparam int THRESH = 0;
  localparam int KK     = KSIZE * KSIZE;
`ifdef BNN_POOL_EN
  localparam int GROUP = 4;
`else
  localparam int GROUP = 1;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  bnn_conv_pool_stream_if #(.KSIZE(KSIZE), .CH(CH)) bus ();
  bnn_conv_pool_stream_if #(.KSIZE(KSIZE), .CH(1))  bus1 ();

  bnn_conv_pool_stream #(.KSIZE(KSIZE), .CH(CH), .THRESH(THRESH)) dut (
    .clk(clk), .rstn(rstn), .bus(bus));
  bnn_conv_pool_stream #(.KSIZE(KSIZE), .CH(1), .THRESH(0)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1));

  typedef struct { bit b; int sum; } exp_t;
  exp_t exp_q[$];
  int   m_sums[$];
  bit   m_acts[$];
  bit   m_err = 1'b0;

  int checks = 0;
  int passes = 0;
  bit rand_ready = 1'b0;
  bit fixed_ready = 1'b1;

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got == req) passes++;
    else $display("FAIL %s: got %0d required %0d", name, got, req);
  endtask

  // Reference: sum of per-channel (matches - mismatches), threshold,
  // then OR over groups of GROUP activations. Returns 1 when an output is due.
  function automatic bit model_beat(input logic [KK-1:0] a, input logic [KK-1:0] w,
                                    input logic last);
    logic [KK-1:0] x;
    int tot;
    bit abit, pooled;
    x = ~(a ^ w);
    if (last != (m_sums.size() == CH - 1)) m_err = 1'b1;
    m_sums.push_back(2 * $countones(x) - KK);
    if (m_sums.size() < CH) return 1'b0;
    tot = 0;
    foreach (m_sums[i]) tot += m_sums[i];
    m_sums.delete();
    abit = (tot >= THRESH);
    m_acts.push_back(abit);
    if (m_acts.size() < GROUP) return 1'b0;
    pooled = 1'b0;
    foreach (m_acts[i]) pooled |= m_acts[i];
    m_acts.delete();
    exp_q.push_back('{pooled, tot});
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
  end

  // Monitor: an output presented with out_ready high is consumed on the next edge.
  always @(negedge clk) begin
    if (!rstn && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_bit", int'(bus.out_bit), int'(e.b));
        check("out_sum", int'(bus.out_sum), e.sum);
      end
    end
  end

  task automatic send_beat(input logic [KK-1:0] a, input logic [KK-1:0] w, input logic last);
    bit took, due;
    int n;
    bus.in_valid = 1'b1; bus.in_act = a; bus.in_wgt = w; bus.in_last_ch = last;
    n = 0;
    took = 1'b0;
    while (!took && n < 200) begin
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!took) begin
      check("beat_accept_timeout", 0, 1);
      return;
    end
    due = model_beat(a, w, last);
    if (due) check("out_valid_latency", int'(bus.out_valid), 1);
    check("ch_err", int'(bus.ch_err), int'(m_err));
  endtask

  task automatic send_rand_beats(input int nb, input bit gaps);
    logic [KK-1:0] a, w;
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      a = KK'($urandom);
      w = KK'($urandom);
      send_beat(a, w, m_sums.size() == CH - 1);
    end
  endtask

  task automatic send_matches(input int m0, input int m1, input int m2);
    logic [KK-1:0] ones;
    int mm[3];
    ones = '1;
    mm[0] = m0; mm[1] = m1; mm[2] = m2;
    for (int i = 0; i < 3; i++) send_beat(ones >> (KK - mm[i]), ones, i == 2);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_out_bit"}, int'(bus.out_bit), 0);
    check({tag, "_out_sum"}, int'(bus.out_sum), 0);
    check({tag, "_ch_err"}, int'(bus.ch_err), 0);
    check({tag, "_in_ready"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_act = '0; bus.in_wgt = '0; bus.in_last_ch = 1'b0;
    bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_act = '0; bus1.in_wgt = '0; bus1.in_last_ch = 1'b0;
    bus1.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;

    // all-match, all-mismatch, threshold boundary at -1 / +1
    send_matches(9, 9, 9);
    send_matches(0, 0, 0);
    send_matches(4, 4, 5);
    send_matches(5, 5, 4);
    // activations 0,0,1,0 then 0,0,0,0
    send_matches(0, 0, 0);
    send_matches(0, 0, 0);
    send_matches(9, 9, 9);
    send_matches(0, 0, 0);
    send_matches(0, 0, 0);
    send_matches(0, 0, 0);
    send_matches(0, 0, 0);
    send_matches(0, 0, 0);
    drain();

    // backpressure: output held, input stalled, then released
    fixed_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_rand_beats(GROUP * CH, 1'b0);
    bus.in_valid = 1'b1; bus.in_act = 9'h0AA; bus.in_wgt = 9'h155; bus.in_last_ch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", int'(bus.in_ready), 0);
      check("stall_out_valid", int'(bus.out_valid), 1);
      if (exp_q.size() > 0) begin
        check("stall_out_bit", int'(bus.out_bit), int'(exp_q[0].b));
        check("stall_out_sum", int'(bus.out_sum), exp_q[0].sum);
      end
    end
    fixed_ready = 1'b1;
    send_beat(9'h0AA, 9'h155, 1'b0);
    send_rand_beats(GROUP * CH - 1, 1'b0);
    drain();

    // channel-count disagreement is sticky
    send_beat(9'h1FF, 9'h1FF, 1'b1);
    send_rand_beats(2 * CH - 1, 1'b0);
    check("ch_err_sticky", int'(bus.ch_err), 1);

    // reset mid-neuron
    send_rand_beats(GROUP * CH - 1, 1'b0);
    drain();
    send_rand_beats(1, 1'b0);
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    m_sums.delete(); m_acts.delete(); exp_q.delete(); m_err = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    send_rand_beats(GROUP * CH, 1'b0);
    drain();

    // randomized traffic with random consumer backpressure
    rand_ready = 1'b1;
    send_rand_beats(GROUP * CH * 12, 1'b1);
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    drain();

`ifndef BNN_POOL_EN
    // single-channel instance: output handshake coincident with a new completion
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_act = 9'h1FF; bus1.in_wgt = 9'h1FF; bus1.in_last_ch = 1'b1;
    @(negedge clk);
    check("c1_in_ready_first", int'(bus1.in_ready), 1);
    @(posedge clk);
    #1;
    check("c1_out_valid_first", int'(bus1.out_valid), 1);
    check("c1_out_bit_first", int'(bus1.out_bit), 1);
    check("c1_out_sum_first", int'(bus1.out_sum), 9);
    bus1.in_act = 9'h000; bus1.out_ready = 1'b1;
    @(negedge clk);
    check("c1_in_ready_coincident", int'(bus1.in_ready), 1);
    @(posedge clk);
    #1;
    check("c1_out_valid_coincident", int'(bus1.out_valid), 1);
    check("c1_out_bit_coincident", int'(bus1.out_bit), 0);
    check("c1_out_sum_coincident", int'(bus1.out_sum), -9);
    bus1.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("c1_out_valid_drained", int'(bus1.out_valid), 0);
    check("c1_out_sum_retained", int'(bus1.out_sum), -9);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
